// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encoding, classic 5-stage pipeline indices and a bit-range mask helper.
package hazard_pkg;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } hazard_state_t;

  localparam int IF_IDX  = 0;
  localparam int ID_IDX  = 1;
  localparam int EX_IDX  = 2;
  localparam int MEM_IDX = 3;
  localparam int WB_IDX  = 4;

  // Returns a 32-bit word with bits lo..hi (inclusive) set.
  function automatic logic [31:0] range_mask(input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 32; b++) begin
      if (b >= lo && b <= hi) begin
        m[b] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter: increments when i_inc is high, sticks at all-ones.
module hazard_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // Count enabled cycles, holding at the maximum value once reached.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: turns load-use, taken-branch and multi-cycle
// MUL/DIV events into PC enable, per-register enables and bubble flushes.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is
// defined; otherwise stall_cycles/flush_events are tied to zero.
// STAGE_EX must lie in 2..NUM_STAGES-2.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int NUM_STAGES    = 5,
  parameter int STAGE_EX      = EX_IDX,
  parameter int MD_MAX_CYCLES = 40,
  parameter int CNT_W         = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_use_hazard,
  input  logic                  branch_taken_ex,
  input  logic                  md_start,
  input  logic                  md_done,
  output logic                  pc_enable,
  output logic [NUM_STAGES-2:0] stage_enable,
  output logic [NUM_STAGES-2:0] stage_flush,
  output logic                  md_busy,
  output logic                  md_timeout,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
);

  localparam int NR   = NUM_STAGES - 1;
  localparam int WD_W = $clog2(MD_MAX_CYCLES + 1);

  // Load-use: freeze everything in front of ID/EX, bubble into EX.
  localparam logic [NR-1:0] LU_HOLD  = NR'(range_mask(0, STAGE_EX - 2));
  localparam logic [NR-1:0] LU_BUB   = NR'(range_mask(STAGE_EX - 1, STAGE_EX - 1));
  // Taken branch: squash the wrong-path instructions fetched behind it.
  localparam logic [NR-1:0] BR_FLUSH = NR'(range_mask(0, STAGE_EX - 1));
  // MUL/DIV: hold the op in EX, bubble into MEM, let older ones drain.
  localparam logic [NR-1:0] MD_HOLD  = NR'(range_mask(0, STAGE_EX - 1));
  localparam logic [NR-1:0] MD_BUB   = NR'(range_mask(STAGE_EX, STAGE_EX));

  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MD_MAX_CYCLES - 1);

  hazard_state_t   r_state;
  hazard_state_t   w_state_next;
  logic [WD_W-1:0] r_wd;
  logic [WD_W-1:0] w_wd_next;

  // State and watchdog registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_wd    <= '0;
    end else begin
      r_state <= w_state_next;
      r_wd    <= w_wd_next;
    end
  end

  // Next-state and pipeline control outputs.
  always_comb begin
    w_state_next = r_state;
    w_wd_next    = r_wd;
    pc_enable    = 1'b1;
    stage_enable = '1;
    stage_flush  = '0;
    md_timeout   = 1'b0;

    case (r_state)
      ST_RUN: begin
        w_wd_next = '0;
        if (branch_taken_ex) begin
          stage_flush = BR_FLUSH;
        end else if (md_start && !md_done) begin
          // The stall starts in the md_start cycle so the op stays in EX
          // on the next edge instead of being overwritten from ID.
          w_state_next = ST_MD_WAIT;
          pc_enable    = 1'b0;
          stage_enable = ~MD_HOLD;
          stage_flush  = MD_BUB;
        end else if (load_use_hazard) begin
          pc_enable    = 1'b0;
          stage_enable = ~LU_HOLD;
          stage_flush  = LU_BUB;
        end
      end
      ST_MD_WAIT: begin
        // Hazard and new-start inputs are meaningless while EX is occupied.
        if (md_done) begin
          w_state_next = ST_RUN;
        end else if (r_wd == WD_LAST) begin
          md_timeout   = 1'b1;
          w_state_next = ST_RUN;
        end else begin
          w_wd_next    = r_wd + 1'b1;
          pc_enable    = 1'b0;
          stage_enable = ~MD_HOLD;
          stage_flush  = MD_BUB;
        end
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase

    // Outputs sit at their idle values for as long as reset is held.
    if (reset) begin
      pc_enable    = 1'b1;
      stage_enable = '1;
      stage_flush  = '0;
      md_timeout   = 1'b0;
    end
  end

  assign md_busy = (r_state == ST_MD_WAIT);

`ifdef HAZARD_PERF_CNT_EN
  logic w_stall_inc;
  logic w_flush_inc;

  assign w_stall_inc = ~pc_enable;
  assign w_flush_inc = |stage_flush;

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_stall_inc),
    .o_count (stall_cycles)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_flush_inc),
    .o_count (flush_events)
  );
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (5 stages, EX=2, 4-bit
// counters so saturation is reachable).
module tb_pipeline_hazard_ctrl;

  localparam int NS    = 5;
  localparam int CW    = 4;
  localparam int MDMAX = 40;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_use_hazard = 1'b0;
  logic          branch_taken_ex = 1'b0;
  logic          md_start = 1'b0;
  logic          md_done = 1'b0;
  logic          pc_enable;
  logic [NS-2:0] stage_enable;
  logic [NS-2:0] stage_flush;
  logic          md_busy;
  logic          md_timeout;
  logic [CW-1:0] stall_cycles;
  logic [CW-1:0] flush_events;

  int n_cmp = 0;
  int n_err = 0;

  pipeline_hazard_ctrl #(
    .NUM_STAGES    (NS),
    .STAGE_EX      (2),
    .MD_MAX_CYCLES (MDMAX),
    .CNT_W         (CW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .load_use_hazard (load_use_hazard),
    .branch_taken_ex (branch_taken_ex),
    .md_start        (md_start),
    .md_done         (md_done),
    .pc_enable       (pc_enable),
    .stage_enable    (stage_enable),
    .stage_flush     (stage_flush),
    .md_busy         (md_busy),
    .md_timeout      (md_timeout),
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] in;      // {lu, br, ms, md}
    logic       pc;
    logic [3:0] en;
    logic [3:0] fl;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(string nm, logic [3:0] in, logic pc, logic [3:0] en,
                              logic [3:0] fl, logic busy, logic to);
    vec_t v;
    v.name = nm; v.in = in; v.pc = pc; v.en = en; v.fl = fl; v.busy = busy; v.to = to;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(string nm, logic epc, logic [3:0] een, logic [3:0] efl,
                         logic ebusy, logic eto);
    chk({nm, ".pc_enable"},    32'(pc_enable),    32'(epc));
    chk({nm, ".stage_enable"}, 32'(stage_enable), 32'(een));
    chk({nm, ".stage_flush"},  32'(stage_flush),  32'(efl));
    chk({nm, ".md_busy"},      32'(md_busy),      32'(ebusy));
    chk({nm, ".md_timeout"},   32'(md_timeout),   32'(eto));
    $display("%0t %-14s in lu/br/ms/md=%b%b%b%b pc=%b en=%b fl=%b busy=%b to=%b",
             $time, nm, load_use_hazard, branch_taken_ex, md_start, md_done,
             pc_enable, stage_enable, stage_flush, md_busy, md_timeout);
  endtask

  task automatic chk_cnt(string nm, int exp_stall, int exp_flush);
    chk({nm, ".stall_cycles"}, 32'(stall_cycles), PERF ? 32'(exp_stall) : 32'd0);
    chk({nm, ".flush_events"}, 32'(flush_events), PERF ? 32'(exp_flush) : 32'd0);
  endtask

  // Apply inputs on the falling edge, let combinational outputs settle.
  task automatic drive(logic [3:0] in);
    @(negedge clk);
    {load_use_hazard, branch_taken_ex, md_start, md_done} = in;
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    {load_use_hazard, branch_taken_ex, md_start, md_done} = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk("idle",        4'b0000, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0);
    vecs[1]  = mk("load_use",    4'b1000, 1'b0, 4'b1110, 4'b0010, 1'b0, 1'b0);
    vecs[2]  = mk("after_lu",    4'b0000, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0);
    vecs[3]  = mk("branch",      4'b0100, 1'b1, 4'b1111, 4'b0011, 1'b0, 1'b0);
    vecs[4]  = mk("branch_lu",   4'b1100, 1'b1, 4'b1111, 4'b0011, 1'b0, 1'b0);
    vecs[5]  = mk("md_1cyc",     4'b0011, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0);
    vecs[6]  = mk("after_1cyc",  4'b0000, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0);
    vecs[7]  = mk("branch_md",   4'b0110, 1'b1, 4'b1111, 4'b0011, 1'b0, 1'b0);
    vecs[8]  = mk("after_brmd",  4'b0000, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0);
    vecs[9]  = mk("done_alone",  4'b0001, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0);
    vecs[10] = mk("md_start",    4'b0010, 1'b0, 4'b1100, 4'b0100, 1'b0, 1'b0);
    vecs[11] = mk("wait_ignore", 4'b1110, 1'b0, 4'b1100, 4'b0100, 1'b1, 1'b0);
    vecs[12] = mk("wait_done",   4'b0001, 1'b1, 4'b1111, 4'b0000, 1'b1, 1'b0);
    vecs[13] = mk("back_run",    4'b0000, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0);
    vecs[14] = mk("lu_again",    4'b1000, 1'b0, 4'b1110, 4'b0010, 1'b0, 1'b0);
    vecs[15] = mk("end_idle",    4'b0000, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0);

    // Reset state, checked while reset is still high.
    @(negedge clk);
    #2;
    chk_out("reset", 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0);
    chk_cnt("reset", 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // Single-cycle behaviour table.
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].in);
      chk_out(vecs[i].name, vecs[i].pc, vecs[i].en, vecs[i].fl, vecs[i].busy, vecs[i].to);
    end

    // MUL/DIV with md_done 8 cycles after md_start.
    do_reset();
    drive(4'b0010);
    chk_out("md8_start", 1'b0, 4'b1100, 4'b0100, 1'b0, 1'b0);
    for (int k = 1; k < 8; k++) begin
      drive(4'b0000);
      chk_out($sformatf("md8_wait%0d", k), 1'b0, 4'b1100, 4'b0100, 1'b1, 1'b0);
    end
    drive(4'b0001);
    chk_out("md8_done", 1'b1, 4'b1111, 4'b0000, 1'b1, 1'b0);
    drive(4'b0000);
    chk_out("md8_run", 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0);
    chk_cnt("md8", 8, 8);

    // Watchdog: no md_done; counters continue from 8 and saturate at 15.
    drive(4'b0010);
    chk_out("wd_start", 1'b0, 4'b1100, 4'b0100, 1'b0, 1'b0);
    for (int k = 1; k < MDMAX; k++) begin
      drive(4'b0000);
      if (k == 1 || k == MDMAX - 1) begin
        chk_out($sformatf("wd_wait%0d", k), 1'b0, 4'b1100, 4'b0100, 1'b1, 1'b0);
      end else begin
        chk({$sformatf("wd_wait%0d", k), ".md_timeout"}, 32'(md_timeout), 32'd0);
      end
    end
    drive(4'b0000);
    chk_out("wd_expire", 1'b1, 4'b1111, 4'b0000, 1'b1, 1'b1);
    drive(4'b0000);
    chk_out("wd_run", 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0);
    chk_cnt("wd_sat", 15, 15);

    // Reset in the third MD_WAIT cycle, then a stale md_done.
    do_reset();
    drive(4'b0010);
    drive(4'b0000);
    drive(4'b0000);
    chk_out("rst_pre", 1'b0, 4'b1100, 4'b0100, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_out("rst_mid", 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0);
    chk_cnt("rst_mid", 0, 0);
    @(negedge clk);
    reset = 1'b0;
    md_done = 1'b1;
    #2;
    chk_out("rst_stale_done", 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0);
    drive(4'b0000);
    chk_out("rst_after", 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0);
    chk_cnt("rst_after", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
